// File: rtl/rtc_write_sequencer_pkg.sv
// Shared constants and types for the RTC register write sequencer:
// register address map, commit command bytes, FSM and group encodings.
package rtc_write_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned NGRP   = 3;

    // Time group registers
    localparam logic [DATA_W-1:0] ADDR_SEC   = 8'h21;
    localparam logic [DATA_W-1:0] ADDR_MIN   = 8'h22;
    localparam logic [DATA_W-1:0] ADDR_HOUR  = 8'h23;
    // Date group registers
    localparam logic [DATA_W-1:0] ADDR_DAY   = 8'h24;
    localparam logic [DATA_W-1:0] ADDR_MONTH = 8'h25;
    localparam logic [DATA_W-1:0] ADDR_YEAR  = 8'h26;
    // Timer group registers
    localparam logic [DATA_W-1:0] ADDR_TSEC  = 8'h41;
    localparam logic [DATA_W-1:0] ADDR_TMIN  = 8'h42;
    localparam logic [DATA_W-1:0] ADDR_THOUR = 8'h43;
    // Command register and commit bytes
    localparam logic [DATA_W-1:0] ADDR_CMD       = 8'hF0;
    localparam logic [DATA_W-1:0] CMD_XFER_TIME  = 8'hF1;
    localparam logic [DATA_W-1:0] CMD_XFER_TIMER = 8'hF2;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_wr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_COMMIT = 3'd5,
        ST_CWAIT  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        GRP_TIME  = 2'd0,
        GRP_DATE  = 2'd1,
        GRP_TIMER = 2'd2
    } group_t;

    // Register address of element idx (0..2) within a group
    function automatic logic [DATA_W-1:0] reg_addr(input group_t grp, input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] addr;
        addr = ADDR_SEC;
        case (grp)
            GRP_DATE: begin
                case (idx)
                    2'd0:    addr = ADDR_DAY;
                    2'd1:    addr = ADDR_MONTH;
                    default: addr = ADDR_YEAR;
                endcase
            end
            GRP_TIMER: begin
                case (idx)
                    2'd0:    addr = ADDR_TSEC;
                    2'd1:    addr = ADDR_TMIN;
                    default: addr = ADDR_THOUR;
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    addr = ADDR_SEC;
                    2'd1:    addr = ADDR_MIN;
                    default: addr = ADDR_HOUR;
                endcase
            end
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_wr_timeout.sv
// Wait-state watchdog: counts enabled cycles since the last clear and
// raises expired once TIMEOUT cycles have elapsed.
module rtc_wr_timeout
    import rtc_write_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Saturates at TIMEOUT; expired is registered alongside the count
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable && !expired) begin
            count   <= count + CW'(1);
            expired <= ((count + CW'(1)) == CW'(TIMEOUT));
        end
    end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Serialises time/date/timer group updates into single-register bus writes,
// each group followed by a commit write to the RTC command register.
module rtc_write_sequencer
    import rtc_write_sequencer_pkg::*;
#(
    parameter logic [7:0]  CMD_ADDR   = ADDR_CMD,
    parameter logic [7:0]  XFER_TIME  = CMD_XFER_TIME,
    parameter logic [7:0]  XFER_TIMER = CMD_XFER_TIMER,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_time,
    input  logic       req_date,
    input  logic       req_timer,
    input  logic [7:0] sec_in,
    input  logic [7:0] min_in,
    input  logic [7:0] hour_in,
    input  logic [7:0] day_in,
    input  logic [7:0] month_in,
    input  logic [7:0] year_in,
    input  logic [7:0] tsec_in,
    input  logic [7:0] tmin_in,
    input  logic [7:0] thour_in,
    input  logic       bus_done,
    output logic       bus_start,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_data,
    output logic       busy,
    output logic       group_done,
    output logic       error
);

    state_t              state, state_n;
    group_t              grp, grp_n;
    logic [NGRP-1:0]     pending, pending_n, clr_mask;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [DATA_W-1:0]   snap0, snap1, snap2;
    logic [DATA_W-1:0]   live0, live1, live2;
    bus_wr_t             wr_q, wr_n;
    logic                start_n, gdone_n, err_n, busy_n;
    logic                tmo_clear, tmo_en, tmo_expired;

    function automatic logic [DATA_W-1:0] pick(input logic [IDX_W-1:0] i,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] v;
        case (i)
            2'd0:    v = a;
            2'd1:    v = b;
            default: v = c;
        endcase
        return v;
    endfunction

    // Live input values of the group being loaded
    always_comb begin
        live0 = sec_in;
        live1 = min_in;
        live2 = hour_in;
        case (grp)
            GRP_DATE: begin
                live0 = day_in;
                live1 = month_in;
                live2 = year_in;
            end
            GRP_TIMER: begin
                live0 = tsec_in;
                live1 = tmin_in;
                live2 = thour_in;
            end
            default: begin
                live0 = sec_in;
                live1 = min_in;
                live2 = hour_in;
            end
        endcase
    end

    assign tmo_en    = (state == ST_WAIT) || (state == ST_CWAIT);
    assign tmo_clear = !tmo_en;

    rtc_wr_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // Next-state and registered-output values
    always_comb begin
        state_n  = state;
        grp_n    = grp;
        idx_n    = idx;
        wr_n     = wr_q;
        clr_mask = '0;
        start_n  = 1'b0;
        gdone_n  = 1'b0;
        err_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_n = ST_LOAD;
                    idx_n   = '0;
                    if (pending[0]) begin
                        grp_n    = GRP_TIME;
                        clr_mask = 3'b001;
                    end else if (pending[1]) begin
                        grp_n    = GRP_DATE;
                        clr_mask = 3'b010;
                    end else begin
                        grp_n    = GRP_TIMER;
                        clr_mask = 3'b100;
                    end
                end
            end
            ST_LOAD: begin
                // Snapshot lands this edge, so the first write takes the live value
                state_n = ST_ISSUE;
                start_n = 1'b1;
                wr_n    = '{addr: reg_addr(grp, idx), data: live0};
            end
            ST_ISSUE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_done) begin
                    state_n = ST_NEXT;
                end else if (tmo_expired) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end
            end
            ST_NEXT: begin
                start_n = 1'b1;
                if (idx < IDX_W'(2)) begin
                    state_n = ST_ISSUE;
                    idx_n   = idx + IDX_W'(1);
                    wr_n    = '{addr: reg_addr(grp, idx_n), data: pick(idx_n, snap0, snap1, snap2)};
                end else begin
                    state_n = ST_COMMIT;
                    wr_n    = '{addr: CMD_ADDR, data: (grp == GRP_TIMER) ? XFER_TIMER : XFER_TIME};
                end
            end
            ST_COMMIT: begin
                state_n = ST_CWAIT;
            end
            ST_CWAIT: begin
                if (bus_done) begin
                    state_n = ST_IDLE;
                    gdone_n = 1'b1;
                end else if (tmo_expired) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A new request for the group being served re-arms it rather than being lost
        pending_n = (pending & ~clr_mask) | {req_timer, req_date, req_time};
        busy_n    = (state_n != ST_IDLE) || (pending_n != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grp        <= GRP_TIME;
            pending    <= '0;
            idx        <= '0;
            wr_q       <= '0;
            bus_start  <= 1'b0;
            group_done <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            grp        <= grp_n;
            pending    <= pending_n;
            idx        <= idx_n;
            wr_q       <= wr_n;
            bus_start  <= start_n;
            group_done <= gdone_n;
            error      <= err_n;
            busy       <= busy_n;
        end
    end

    // Group data is frozen in LOAD so later input changes cannot leak in
    always_ff @(posedge clk) begin
        if (reset) begin
            snap0 <= '0;
            snap1 <= '0;
            snap2 <= '0;
        end else if (state == ST_LOAD) begin
            snap0 <= live0;
            snap1 <= live1;
            snap2 <= live2;
        end
    end

    assign bus_addr = wr_q.addr;
    assign bus_data = wr_q.data;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: expected bus writes are queued
// when a request is driven and checked as the DUT launches each write.
module tb_rtc_write_sequencer;

    localparam int unsigned TB_TIMEOUT = 20;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_time = 1'b0, req_date = 1'b0, req_timer = 1'b0;
    logic [7:0] sec_in = '0, min_in = '0, hour_in = '0;
    logic [7:0] day_in = '0, month_in = '0, year_in = '0;
    logic [7:0] tsec_in = '0, tmin_in = '0, thour_in = '0;
    logic       resp_done = 1'b0, stray_done = 1'b0;
    logic       bus_done;
    logic       bus_start, busy, group_done, error;
    logic [7:0] bus_addr, bus_data;

    int  checks = 0, failures = 0;
    int  gd_cnt = 0, err_cnt = 0, start_cnt = 0;
    bit  resp_en = 1'b1, abort_resp = 1'b0;
    wr_t sb[$];

    assign bus_done = resp_done | stray_done;

    rtc_write_sequencer #(
        .CMD_ADDR   (8'hF0),
        .XFER_TIME  (8'hF1),
        .XFER_TIMER (8'hF2),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_time   (req_time),
        .req_date   (req_date),
        .req_timer  (req_timer),
        .sec_in     (sec_in),
        .min_in     (min_in),
        .hour_in    (hour_in),
        .day_in     (day_in),
        .month_in   (month_in),
        .year_in    (year_in),
        .tsec_in    (tsec_in),
        .tmin_in    (tmin_in),
        .thour_in   (thour_in),
        .bus_done   (bus_done),
        .bus_start  (bus_start),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .busy       (busy),
        .group_done (group_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pulse counters
    initial begin
        forever begin
            @(negedge clk);
            if (group_done === 1'b1) gd_cnt++;
            if (error === 1'b1)      err_cnt++;
            if (bus_start === 1'b1)  start_cnt++;
        end
    end

    // Bus engine model: scoreboard check on each start, ack two cycles later
    initial begin
        wr_t exp_w, cur;
        forever begin
            @(negedge clk);
            if (bus_start === 1'b1) begin
                cur = '{addr: bus_addr, data: bus_data};
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got=%h/%h required=none", bus_addr, bus_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (cur !== exp_w) begin
                        failures++;
                        $display("FAIL write_payload got=%h/%h required=%h/%h",
                                 cur.addr, cur.data, exp_w.addr, exp_w.data);
                    end
                end
                if (resp_en) begin
                    for (int i = 0; i < 2; i++) begin
                        @(negedge clk);
                        if (abort_resp) break;
                        checks++;
                        if ({bus_addr, bus_data} !== {cur.addr, cur.data}) begin
                            failures++;
                            $display("FAIL write_stable got=%h/%h required=%h/%h",
                                     bus_addr, bus_data, cur.addr, cur.data);
                        end
                    end
                    if (!abort_resp) begin
                        resp_done = 1'b1;
                        @(negedge clk);
                        resp_done = 1'b0;
                        checks++;
                        if ({bus_addr, bus_data} !== {cur.addr, cur.data}) begin
                            failures++;
                            $display("FAIL write_stable_at_done got=%h/%h required=%h/%h",
                                     bus_addr, bus_data, cur.addr, cur.data);
                        end
                    end
                end
            end
        end
    end

    // Expected writes of one group: g 0=time, 1=date, 2=timer
    task automatic push_group(input int g, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] base;
        base = (g == 0) ? 8'h21 : (g == 1) ? 8'h24 : 8'h41;
        sb.push_back('{addr: base,          data: a});
        sb.push_back('{addr: base + 8'd1,   data: b});
        sb.push_back('{addr: base + 8'd2,   data: c});
        sb.push_back('{addr: 8'hF0, data: (g == 2) ? 8'hF2 : 8'hF1});
    endtask

    task automatic pulse_req(input logic t, input logic d, input logic tm);
        req_time = t; req_date = d; req_timer = tm;
        @(negedge clk);
        req_time = 1'b0; req_date = 1'b0; req_timer = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        req_time = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus_start !== 1'b0)  begin failures++; $display("FAIL reset_bus_start got=%b required=0", bus_start); end
        checks++; if (bus_addr !== 8'h00)  begin failures++; $display("FAIL reset_bus_addr got=%h required=00", bus_addr); end
        checks++; if (bus_data !== 8'h00)  begin failures++; $display("FAIL reset_bus_data got=%h required=00", bus_data); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (group_done !== 1'b0) begin failures++; $display("FAIL reset_group_done got=%b required=0", group_done); end
        checks++; if (error !== 1'b0)      begin failures++; $display("FAIL reset_error got=%b required=0", error); end
        reset = 1'b0;
        req_time = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_req_discarded busy=%b required=0", busy); end
        checks++; if (start_cnt !== 0) begin failures++; $display("FAIL reset_req_discarded starts=%0d required=0", start_cnt); end
        // bus_done while idle must be ignored
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || gd_cnt !== 0 || start_cnt !== 0) begin
            failures++;
            $display("FAIL stray_done busy=%b group_done_cnt=%0d starts=%0d required=0/0/0", busy, gd_cnt, start_cnt);
        end
    endtask

    task automatic test_single_time;
        int g0, e0;
        bit ok;
        g0 = gd_cnt; e0 = err_cnt;
        sec_in = 8'h45; min_in = 8'h30; hour_in = 8'h12;
        push_group(0, 8'h45, 8'h30, 8'h12);
        pulse_req(1'b1, 1'b0, 1'b0);
        checks++; if (bus_start !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL latency_c1 start=%b busy=%b required=0/1", bus_start, busy);
        end
        @(negedge clk);
        checks++; if (bus_start !== 1'b0) begin failures++; $display("FAIL latency_c2 start=%b required=0", bus_start); end
        @(negedge clk);
        checks++; if (bus_start !== 1'b1) begin failures++; $display("FAIL latency_c3 start=%b required=1", bus_start); end
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_idle_timeout got=busy required=idle"); end
        checks++; if (group_done !== 1'b1) begin failures++; $display("FAIL single_group_done got=%b required=1", group_done); end
        @(negedge clk);
        checks++; if (gd_cnt - g0 !== 1 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL single_pulses gd=%0d err=%0d required=1/0", gd_cnt - g0, err_cnt - e0);
        end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL single_sb_left got=%0d required=0", sb.size()); end
    endtask

    task automatic test_snapshot;
        int g0;
        bit ok;
        g0 = gd_cnt;
        sec_in = 8'h11; min_in = 8'h22; hour_in = 8'h33;
        push_group(0, 8'h11, 8'h22, 8'h33);
        pulse_req(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        // LOAD is over; these changes must not reach the group in flight
        sec_in = 8'h59; min_in = 8'h58; hour_in = 8'h57;
        checks++; if (bus_data !== 8'h11) begin failures++; $display("FAIL snapshot_first got=%h required=11", bus_data); end
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL snapshot_idle_timeout got=busy required=idle"); end
        @(negedge clk);
        checks++; if (gd_cnt - g0 !== 1 || sb.size() !== 0) begin
            failures++; $display("FAIL snapshot_done gd=%0d sb=%0d required=1/0", gd_cnt - g0, sb.size());
        end
    endtask

    task automatic test_all_three;
        int g0, s0;
        bit ok;
        g0 = gd_cnt; s0 = start_cnt;
        sec_in = 8'h05; min_in = 8'h10; hour_in = 8'h23;
        day_in = 8'h31; month_in = 8'h12; year_in = 8'h99;
        tsec_in = 8'h07; tmin_in = 8'h08; thour_in = 8'h09;
        push_group(0, 8'h05, 8'h10, 8'h23);
        push_group(1, 8'h31, 8'h12, 8'h99);
        push_group(2, 8'h07, 8'h08, 8'h09);
        pulse_req(1'b1, 1'b1, 1'b1);
        wait_idle(600, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL all3_idle_timeout got=busy required=idle"); end
        checks++; if (group_done !== 1'b1) begin failures++; $display("FAIL all3_last_done got=%b required=1", group_done); end
        @(negedge clk);
        checks++; if (gd_cnt - g0 !== 3) begin failures++; $display("FAIL all3_group_done got=%0d required=3", gd_cnt - g0); end
        checks++; if (start_cnt - s0 !== 12) begin failures++; $display("FAIL all3_starts got=%0d required=12", start_cnt - s0); end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL all3_sb_left got=%0d required=0", sb.size()); end
    endtask

    task automatic test_late_timer;
        int g0, n;
        bit ok;
        g0 = gd_cnt; n = 0;
        sec_in = 8'h01; min_in = 8'h02; hour_in = 8'h03;
        tsec_in = 8'h44; tmin_in = 8'h55; thour_in = 8'h06;
        push_group(0, 8'h01, 8'h02, 8'h03);
        push_group(2, 8'h44, 8'h55, 8'h06);
        pulse_req(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_start === 1'b1) n++;
            if (n == 2) break;
        end
        checks++; if (n !== 2) begin failures++; $display("FAIL late_second_write got=%0d required=2", n); end
        pulse_req(1'b0, 1'b0, 1'b1);
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL late_idle_timeout got=busy required=idle"); end
        @(negedge clk);
        checks++; if (gd_cnt - g0 !== 2 || sb.size() !== 0) begin
            failures++; $display("FAIL late_timer_served gd=%0d sb=%0d required=2/0", gd_cnt - g0, sb.size());
        end
    endtask

    task automatic test_timeout;
        int g0, e0, s0, cyc;
        bit found, ok;
        g0 = gd_cnt; e0 = err_cnt; s0 = start_cnt;
        found = 1'b0; cyc = 0;
        resp_en = 1'b0;
        sec_in = 8'h33; day_in = 8'h15; month_in = 8'h06; year_in = 8'h24;
        sb.push_back('{addr: 8'h21, data: 8'h33});
        push_group(1, 8'h15, 8'h06, 8'h24);
        pulse_req(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_start === 1'b1) break;
        end
        for (int i = 0; i < int'(TB_TIMEOUT) + 10; i++) begin
            @(negedge clk);
            cyc++;
            if (error === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        resp_en = 1'b1;
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL timeout_error_seen got=0 required=1"); end
        // One ISSUE cycle, TIMEOUT counted WAIT cycles, then the registered pulse
        checks++; if (cyc !== int'(TB_TIMEOUT) + 2) begin
            failures++; $display("FAIL timeout_latency got=%0d required=%0d", cyc, int'(TB_TIMEOUT) + 2);
        end
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL timeout_idle_timeout got=busy required=idle"); end
        @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_error_pulses got=%0d required=1", err_cnt - e0); end
        checks++; if (gd_cnt - g0 !== 1) begin failures++; $display("FAIL timeout_date_served got=%0d required=1", gd_cnt - g0); end
        checks++; if (start_cnt - s0 !== 5 || sb.size() !== 0) begin
            failures++; $display("FAIL timeout_writes starts=%0d sb=%0d required=5/0", start_cnt - s0, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        int n, s0;
        n = 0;
        day_in = 8'h28; month_in = 8'h02; year_in = 8'h25;
        sb.push_back('{addr: 8'h24, data: 8'h28});
        sb.push_back('{addr: 8'h25, data: 8'h02});
        pulse_req(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_start === 1'b1) n++;
            if (n == 2) break;
        end
        checks++; if (n !== 2) begin failures++; $display("FAIL rmid_second_write got=%0d required=2", n); end
        abort_resp = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({bus_start, busy, group_done, error} !== 4'b0000) begin
            failures++; $display("FAIL rmid_flags got=%b required=0000", {bus_start, busy, group_done, error});
        end
        checks++; if ({bus_addr, bus_data} !== 16'h0000) begin
            failures++; $display("FAIL rmid_bus got=%h/%h required=00/00", bus_addr, bus_data);
        end
        reset = 1'b0;
        @(negedge clk);
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        checks++; if (start_cnt !== s0 || busy !== 1'b0) begin
            failures++; $display("FAIL rmid_no_start starts=%0d busy=%b required=0/0", start_cnt - s0, busy);
        end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL rmid_sb_left got=%0d required=0", sb.size()); end
        abort_resp = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_time;
        test_snapshot;
        test_all_three;
        test_late_timer;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_write_sequencer.md
RTC_WRITE_SEQUENCER -- requirements
Module: rtc_write_sequencer

Interface
REQ-001 Parameter CMD_ADDR, default 8'hF0, command register address written after each group.
REQ-002 Parameter XFER_TIME, default 8'hF1, command byte committing the time and date groups.
REQ-003 Parameter XFER_TIMER, default 8'hF2, command byte committing the timer group.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles spent in WAIT for bus_done.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_time, req_date, req_timer  in  1 each  single-cycle write requests per group.
REQ-008 sec_in, min_in, hour_in  in  8 each  BCD time values.
REQ-009 day_in, month_in, year_in  in  8 each  BCD date values.
REQ-010 tsec_in, tmin_in, thour_in  in  8 each  BCD timer values.
REQ-011 bus_done  in  1  write-transaction engine completion pulse.
REQ-012 bus_start  out  1  one-cycle pulse launching a bus write.
REQ-013 bus_addr, bus_data  out  8 each  register address and data of the current write.
REQ-014 busy  out  1  high whenever FSM is not IDLE or any request is pending.
REQ-015 group_done  out  1  one-cycle pulse after a group's commit write completes.
REQ-016 error  out  1  one-cycle pulse when a bus write times out.

Function
REQ-017 Requests shall be latched into a 3-bit pending register; a request arriving while busy shall be latched, not dropped.
REQ-018 Group priority when several are pending: time > date > timer; the served bit clears on entry to LOAD.
REQ-019 FSM states: IDLE, LOAD, ISSUE, WAIT, NEXT, COMMIT, CWAIT.
REQ-020 IDLE->LOAD when any pending bit is set; LOAD snapshots the group's three data inputs into internal registers.
REQ-021 LOAD->ISSUE; ISSUE asserts bus_start for exactly one cycle, then ->WAIT.
REQ-022 WAIT->NEXT on bus_done; NEXT advances the index 0..2, ->ISSUE if index<2, else ->COMMIT.
REQ-023 Address map: time 0x21,0x22,0x23 = sec,min,hour; date 0x24,0x25,0x26 = day,month,year; timer 0x41,0x42,0x43 = tsec,tmin,thour.
REQ-024 COMMIT issues a one-cycle bus_start with bus_addr=CMD_ADDR and bus_data=XFER_TIME (time/date) or XFER_TIMER (timer), then ->CWAIT.
REQ-025 CWAIT->IDLE on bus_done with group_done pulsed in the following cycle.
REQ-026 bus_addr/bus_data shall be stable from the ISSUE/COMMIT cycle until bus_done is sampled.
REQ-027 bus_done outside WAIT/CWAIT shall be ignored.
REQ-028 Latency: with FSM idle, a request at edge N shall produce bus_start in cycle N+3 (pending, LOAD, ISSUE).
REQ-029 A timeout counter shall clear on entry to WAIT/CWAIT; reaching TIMEOUT shall pulse error, abort the group (no commit write) and return to IDLE; other pending groups are still served.
REQ-030 Input changes after LOAD shall not alter the data of the group in progress.

Reset
REQ-031 On reset: FSM=IDLE; pending, index and timeout counter=0; bus_start, group_done, error, busy=0; bus_addr, bus_data=8'h00.
REQ-032 Reset asserted mid-group shall abort with no further bus_start; requests coinciding with reset are discarded.

Structure
REQ-033 A shared package shall hold the register address constants (0x21..0x26, 0x41..0x43, 0xF0), the command bytes and the FSM state encoding.
REQ-034 The timeout counter shall be the single sub-module, rtc_wr_timeout (clear, enable, expired).

Verification
REQ-035 req_time with sec=0x45, min=0x30, hour=0x12, bus_done 2 cycles after each start -> writes (21,45),(22,30),(23,12),(F0,F1), then one group_done.
REQ-036 req_time, req_date, req_timer in the same cycle -> time, then date (24..26,F0/F1), then timer (41..43,F0/F2); three group_done pulses; busy low only at the end.
REQ-037 req_timer during the time group's second write -> timer group starts after the time commit; the request is not lost.
REQ-038 bus_done withheld -> error pulses after TIMEOUT cycles, no F0 write, FSM back to IDLE.
REQ-039 reset asserted during WAIT of the second date write -> all outputs 0 the next cycle; no further bus_start.
REQ-040 sec_in changed one cycle after LOAD -> the first write still carries the snapshot value.
